// File: rtl/xcvr_rmw_engine.sv
// xcvr_rmw_engine
// Command executor sitting between the fPLL/transceiver recalibration
// sequencers and the reconfiguration controller Avalon-MM management port.
// A single-cycle command pulse accepted in IDLE becomes one of these:
//   - masked read-modify-write of cmd_address
//   - write to the arbitration register (request or release the config bus)
//   - wait for the PLL/channel to drop cal_busy, with a sticky timeout flag
// busy is high for the whole life of an accepted command.
//
// Optional build macro RMW_VERIFY_EN: after the RMW write, re-read the same
// address and compare the masked bits. A mismatch sets the sticky output
// verify_err, which exists only when the macro is defined.

module xcvr_rmw_engine #(
    parameter logic [9:0]  ADDR_ARB     = 10'h000,
    parameter logic [31:0] ARB_REQ_DATA = 32'h2,
    parameter logic [31:0] ARB_REL_DATA = 32'h1,
    parameter int          CAL_SETTLE   = 16,
    parameter int          CAL_TIMEOUT  = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_reconfig,
    input  logic        cmd_req_cbus,
    input  logic        cmd_rel_cbus,
    input  logic        cmd_wcalib,
    input  logic [9:0]  cmd_address,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        busy,
    output logic        cal_timeout,
    output logic [9:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    output logic        mgmt_write,
    output logic        mgmt_read,
    input  logic        mgmt_waitrequest,
`ifdef RMW_VERIFY_EN
    output logic        verify_err,
`endif
    input  logic        cal_busy
);

    // State encoding kept as plain constants so older tools can read it.
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_ARBW   = 4'd1;
    localparam logic [3:0] S_RD     = 4'd2;
    localparam logic [3:0] S_MOD    = 4'd3;
    localparam logic [3:0] S_WR     = 4'd4;
    localparam logic [3:0] S_VRD    = 4'd5;
    localparam logic [3:0] S_CMP    = 4'd6;
    localparam logic [3:0] S_SETTLE = 4'd7;
    localparam logic [3:0] S_WCAL   = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    // The timeout counter runs from the wcalib command until CAL_TIMEOUT.
    localparam int TMO_W = $clog2(CAL_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(CAL_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CAL_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    // The settle counter counts CAL_SETTLE cycles spent in SETTLE.
    localparam int SET_W = (CAL_SETTLE > 1) ? $clog2(CAL_SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(CAL_SETTLE - 1);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

    logic [3:0]       state_q,   state_d;
    logic             busy_q,    busy_d;
    logic             caltmo_q,  caltmo_d;
    logic [9:0]       addr_q,    addr_d;
    logic [31:0]      wdata_q,   wdata_d;
    logic             read_q,    read_d;
    logic             write_q,   write_d;
    logic [31:0]      data_q,    data_d;
    logic [31:0]      mask_q,    mask_d;
    logic [31:0]      rdata_q,   rdata_d;
    logic [SET_W-1:0] settle_q,  settle_d;
    logic [TMO_W-1:0] tmo_q,     tmo_d;
`ifdef RMW_VERIFY_EN
    logic             verr_q,    verr_d;
`endif

    logic xfer_done;

    // A strobed transfer finishes on the first cycle waitrequest is low.
    assign xfer_done = ~mgmt_waitrequest;

    assign busy           = busy_q;
    assign cal_timeout    = caltmo_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = wdata_q;
    assign mgmt_read      = read_q;
    assign mgmt_write     = write_q;
`ifdef RMW_VERIFY_EN
    assign verify_err     = verr_q;
`endif

    // Next-state logic: command decode, Avalon handshakes and wait counters.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        caltmo_d = caltmo_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        read_d   = read_q;
        write_d  = write_q;
        data_d   = data_q;
        mask_d   = mask_q;
        rdata_d  = rdata_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
`ifdef RMW_VERIFY_EN
        verr_d   = verr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_req_cbus) begin
                    state_d = S_ARBW;
                    busy_d  = 1'b1;
                    addr_d  = ADDR_ARB;
                    wdata_d = ARB_REQ_DATA;
                    write_d = 1'b1;
                end else if (cmd_rel_cbus) begin
                    state_d = S_ARBW;
                    busy_d  = 1'b1;
                    addr_d  = ADDR_ARB;
                    wdata_d = ARB_REL_DATA;
                    write_d = 1'b1;
                end else if (cmd_reconfig) begin
                    state_d = S_RD;
                    busy_d  = 1'b1;
                    addr_d  = cmd_address;
                    data_d  = cmd_data;
                    mask_d  = cmd_mask;
                    read_d  = 1'b1;
                end else if (cmd_wcalib) begin
                    state_d  = S_SETTLE;
                    busy_d   = 1'b1;
                    settle_d = '0;
                    tmo_d    = '0;
                end
            end

            S_ARBW: begin
                if (xfer_done) begin
                    write_d = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_RD: begin
                if (xfer_done) begin
                    read_d  = 1'b0;
                    rdata_d = mgmt_readdata;
                    state_d = S_MOD;
                end
            end

            S_MOD: begin
                wdata_d = (rdata_q & ~mask_q) | (data_q & mask_q);
                write_d = 1'b1;
                state_d = S_WR;
            end

            S_WR: begin
                if (xfer_done) begin
                    write_d = 1'b0;
`ifdef RMW_VERIFY_EN
                    read_d  = 1'b1;
                    state_d = S_VRD;
`else
                    state_d = S_DONE;
`endif
                end
            end

`ifdef RMW_VERIFY_EN
            S_VRD: begin
                if (xfer_done) begin
                    read_d  = 1'b0;
                    rdata_d = mgmt_readdata;
                    state_d = S_CMP;
                end
            end

            S_CMP: begin
                if (((rdata_q ^ wdata_q) & mask_q) != 32'h0) begin
                    verr_d = 1'b1;
                end
                state_d = S_DONE;
            end
`endif

            S_SETTLE: begin
                if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + TMO_ONE;
                end
                if (settle_q >= SET_LAST) begin
                    state_d = S_WCAL;
                end else begin
                    settle_d = settle_q + SET_ONE;
                end
            end

            S_WCAL: begin
                if (!cal_busy) begin
                    state_d = S_DONE;
                end else begin
                    if (tmo_q != TMO_MAX) begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                    if (tmo_q >= TMO_LAST) begin
                        caltmo_d = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            caltmo_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            data_q   <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
`ifdef RMW_VERIFY_EN
            verr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            caltmo_q <= caltmo_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            read_q   <= read_d;
            write_q  <= write_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            rdata_q  <= rdata_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
`ifdef RMW_VERIFY_EN
            verr_q   <= verr_d;
`endif
        end
    end

endmodule

// File: tb/tb_xcvr_rmw_engine.sv
// tb_xcvr_rmw_engine
// Self-checking bench: a memory-backed Avalon slave with programmable wait
// states logs every completed transfer; each test task compares the log and
// busy latency against values worked out from the command rules.
// A second engine instance with a short calibration timeout covers the
// timeout path. Build with RMW_VERIFY_EN defined to cover the verify path.

module tb_xcvr_rmw_engine;

    localparam int SETTLE   = 16;
    localparam int TO_SHORT = 50;
`ifdef RMW_VERIFY_EN
    localparam int VX  = 2;
    localparam int VTX = 3;
`else
    localparam int VX  = 0;
    localparam int VTX = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_reconfig, cmd_req_cbus, cmd_rel_cbus, cmd_wcalib;
    logic [9:0]  cmd_address;
    logic [31:0] cmd_data, cmd_mask;
    logic        busy, cal_timeout;
    logic [9:0]  mgmt_address;
    logic [31:0] mgmt_writedata, mgmt_readdata;
    logic        mgmt_write, mgmt_read, mgmt_waitrequest;
    logic        cal_busy;
`ifdef RMW_VERIFY_EN
    logic        verify_err, to_verify_err;
`endif

    logic        to_wcalib;
    logic        to_busy, to_cal_timeout;
    logic [9:0]  to_address;
    logic [31:0] to_writedata;
    logic        to_write, to_read;

    int total = 0;
    int bad   = 0;

    // Slave model state
    logic [31:0] mem [0:1023];
    int          wait_cfg;
    int          wcnt;
    logic        drop_writes;
    int          proto_err;
    logic        stalled;
    logic        p_rd, p_wr;
    logic [9:0]  p_addr;
    logic [31:0] p_wd;
    int          q_kind[$];
    logic [9:0]  q_addr[$];
    logic [31:0] q_data[$];

    always #5 clk = ~clk;

    xcvr_rmw_engine dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_reconfig     (cmd_reconfig),
        .cmd_req_cbus     (cmd_req_cbus),
        .cmd_rel_cbus     (cmd_rel_cbus),
        .cmd_wcalib       (cmd_wcalib),
        .cmd_address      (cmd_address),
        .cmd_data         (cmd_data),
        .cmd_mask         (cmd_mask),
        .busy             (busy),
        .cal_timeout      (cal_timeout),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_waitrequest (mgmt_waitrequest),
`ifdef RMW_VERIFY_EN
        .verify_err       (verify_err),
`endif
        .cal_busy         (cal_busy)
    );

    xcvr_rmw_engine #(.CAL_TIMEOUT(TO_SHORT)) dut_to (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_reconfig     (1'b0),
        .cmd_req_cbus     (1'b0),
        .cmd_rel_cbus     (1'b0),
        .cmd_wcalib       (to_wcalib),
        .cmd_address      (10'h0),
        .cmd_data         (32'h0),
        .cmd_mask         (32'h0),
        .busy             (to_busy),
        .cal_timeout      (to_cal_timeout),
        .mgmt_address     (to_address),
        .mgmt_writedata   (to_writedata),
        .mgmt_readdata    (32'h0),
        .mgmt_write       (to_write),
        .mgmt_read        (to_read),
        .mgmt_waitrequest (1'b0),
`ifdef RMW_VERIFY_EN
        .verify_err       (to_verify_err),
`endif
        .cal_busy         (cal_busy)
    );

    assign mgmt_waitrequest = (mgmt_read || mgmt_write) && (wcnt < wait_cfg);
    assign mgmt_readdata    = mem[mgmt_address];

    // Slave: stretch each transfer by wait_cfg cycles, log completions,
    // and count protocol violations (two strobes, or signals moving while stalled).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt    <= 0;
            stalled <= 1'b0;
        end else begin
            if (mgmt_read && mgmt_write) proto_err++;
            if (stalled && (mgmt_read !== p_rd || mgmt_write !== p_wr ||
                            mgmt_address !== p_addr || (p_wr && mgmt_writedata !== p_wd)))
                proto_err++;
            if (mgmt_read || mgmt_write) begin
                if (mgmt_waitrequest) begin
                    wcnt    <= wcnt + 1;
                    stalled <= 1'b1;
                    p_rd    <= mgmt_read;
                    p_wr    <= mgmt_write;
                    p_addr  <= mgmt_address;
                    p_wd    <= mgmt_writedata;
                end else begin
                    q_kind.push_back(mgmt_write ? 1 : 0);
                    q_addr.push_back(mgmt_address);
                    q_data.push_back(mgmt_writedata);
                    if (mgmt_write && !drop_writes) mem[mgmt_address] <= mgmt_writedata;
                    wcnt    <= 0;
                    stalled <= 1'b0;
                end
            end else begin
                stalled <= 1'b0;
            end
        end
    end

    task automatic clear_log();
        q_kind.delete();
        q_addr.delete();
        q_data.delete();
        proto_err = 0;
    endtask

    // Pulse commands for one cycle, then count posedges (including the
    // accepting one) until busy is seen low; -1 if it never drops.
    task automatic issue_cmd(input logic [3:0] kinds, input logic [9:0] addr,
                             input logic [31:0] data, input logic [31:0] mask,
                             input int cal_drop, output int edges, output logic busy_first);
        @(negedge clk);
        cmd_req_cbus = kinds[0];
        cmd_rel_cbus = kinds[1];
        cmd_reconfig = kinds[2];
        cmd_wcalib   = kinds[3];
        cmd_address  = addr;
        cmd_data     = data;
        cmd_mask     = mask;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        cmd_req_cbus = 1'b0;
        cmd_rel_cbus = 1'b0;
        cmd_reconfig = 1'b0;
        cmd_wcalib   = 1'b0;
        busy_first   = busy;
        while (busy && edges < 2000) begin
            if (cal_drop > 0 && edges == cal_drop) cal_busy = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (busy) edges = -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (cal_timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_caltmo got=%b want=0", cal_timeout); end
        total++; if ({mgmt_read, mgmt_write} !== 2'b00) begin bad++; $display("[TB] FAIL reset_strobes got=%b want=00", {mgmt_read, mgmt_write}); end
        total++; if (mgmt_address !== 10'h0 || mgmt_writedata !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_bus got=%h/%h want=000/00000000", mgmt_address, mgmt_writedata); end
`ifdef RMW_VERIFY_EN
        total++; if (verify_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_verr got=%b want=0", verify_err); end
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Check a logged RMW: read then write of expected data at addr.
    task automatic test_rmw_case(input string tag, input logic [9:0] a, input logic [31:0] d,
                                 input logic [31:0] m, input int w);
        logic [31:0] old, exp;
        int          edges;
        logic        bf;
        wait_cfg = w;
        old = mem[a];
        exp = (old & ~m) | (d & m);
        clear_log();
        issue_cmd(4'b0100, a, d, m, 0, edges, bf);
        total++; if (bf !== 1'b1) begin bad++; $display("[TB] FAIL %s_busy_first got=%b want=1", tag, bf); end
        total++; if (edges != 5 + VX + w * VTX) begin
            bad++; $display("[TB] FAIL %s_latency got=%0d want=%0d", tag, edges, 5 + VX + w * VTX); end
        total++; if (q_kind.size() != VTX) begin
            bad++; $display("[TB] FAIL %s_txn_count got=%0d want=%0d", tag, q_kind.size(), VTX);
        end else begin
            if (q_kind[0] != 0 || q_addr[0] !== a) begin
                bad++; $display("[TB] FAIL %s_read got=%0d@%h want=0@%h", tag, q_kind[0], q_addr[0], a); end
            total++;
            if (q_kind[1] != 1 || q_addr[1] !== a || q_data[1] !== exp) begin
                bad++; $display("[TB] FAIL %s_write got=%0d@%h:%h want=1@%h:%h", tag, q_kind[1], q_addr[1], q_data[1], a, exp); end
        end
        total++; if (mem[a] !== exp) begin bad++; $display("[TB] FAIL %s_mem got=%h want=%h", tag, mem[a], exp); end
        total++; if (proto_err != 0) begin bad++; $display("[TB] FAIL %s_protocol got=%0d want=0", tag, proto_err); end
    endtask

    task automatic test_rmw();
        mem[10'h12b] = 32'hA5A5_00F0;
        test_rmw_case("rmw_directed", 10'h12b, 32'h3C, 32'hFF, 0);
        total++; if (mem[10'h12b] !== 32'hA5A5_003C) begin
            bad++; $display("[TB] FAIL rmw_directed_value got=%h want=a5a5003c", mem[10'h12b]); end
    endtask

    task automatic test_rmw_random();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] m;
            m = (i == 0) ? 32'h0 : (i == 1) ? 32'hFFFF_FFFF : $urandom;
            test_rmw_case("rmw_rand", 10'($urandom_range(1023)), $urandom, m, $urandom_range(3));
        end
    endtask

    task automatic test_waitrequest();
        test_rmw_case("wait7", 10'h055, 32'h1234_5678, 32'h00FF_FF00, 7);
        wait_cfg = 0;
    endtask

    task automatic test_arbitration();
        logic [3:0] combos [5];
        combos[0] = 4'b0101; combos[1] = 4'b1111; combos[2] = 4'b0110;
        combos[3] = 4'b0010; combos[4] = 4'b0001;
        wait_cfg = 0;
        for (int i = 0; i < 5; i++) begin
            int          edges;
            logic        bf;
            logic [31:0] expd;
            expd = combos[i][0] ? 32'h2 : 32'h1;
            clear_log();
            issue_cmd(combos[i], 10'h3AA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, edges, bf);
            total++; if (edges != 3) begin bad++; $display("[TB] FAIL arb_latency i=%0d got=%0d want=3", i, edges); end
            total++; if (q_kind.size() != 1) begin
                bad++; $display("[TB] FAIL arb_txn_count i=%0d got=%0d want=1", i, q_kind.size());
            end else if (q_kind[0] != 1 || q_addr[0] !== 10'h000 || q_data[0] !== expd) begin
                bad++; $display("[TB] FAIL arb_write i=%0d got=%0d@%h:%h want=1@000:%h", i, q_kind[0], q_addr[0], q_data[0], expd);
            end
        end
        // reconfig outranks wcalib: an RMW happens
        mem[10'h077] = 32'h0F0F_0F0F;
        wait_cfg = 0;
        begin
            int   edges;
            logic bf;
            clear_log();
            issue_cmd(4'b1100, 10'h077, 32'hFFFF_FFFF, 32'h0000_00F0, 0, edges, bf);
            total++; if (edges != 5 + VX || mem[10'h077] !== 32'h0F0F_0FFF) begin
                bad++; $display("[TB] FAIL arb_rmw_over_wcalib got=%0d/%h want=%0d/0f0f0fff", edges, mem[10'h077], 5 + VX); end
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        wait_cfg = 4;
        clear_log();
        @(negedge clk);
        cmd_reconfig = 1'b1; cmd_address = 10'h200; cmd_data = 32'hAAAA_AAAA; cmd_mask = 32'hFFFF_0000;
        @(negedge clk);
        cmd_reconfig = 1'b0;
        repeat (2) @(negedge clk);
        cmd_req_cbus = 1'b1;
        @(negedge clk);
        cmd_req_cbus = 1'b0;
        edges = 0;
        while (busy && edges < 200) begin @(negedge clk); edges++; end
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle got=%b want=0", busy); end
        total++; if (q_kind.size() != VTX) begin
            bad++; $display("[TB] FAIL b2b_ignored_cmd got=%0d want=%0d", q_kind.size(), VTX); end
        wait_cfg = 0;
        test_rmw_case("b2b_next", 10'h200, 32'h5555_5555, 32'h0000_FFFF, 0);
    endtask

    task automatic test_cal_wait();
        int   edges;
        logic bf;
        clear_log();
        cal_busy = 1'b1;
        issue_cmd(4'b1000, 10'h0, 32'h0, 32'h0, SETTLE + 100 + 1, edges, bf);
        total++; if (edges != SETTLE + 100 + 3) begin
            bad++; $display("[TB] FAIL cal_latency got=%0d want=%0d", edges, SETTLE + 100 + 3); end
        total++; if (cal_timeout !== 1'b0) begin bad++; $display("[TB] FAIL cal_no_timeout got=%b want=0", cal_timeout); end
        total++; if (q_kind.size() != 0) begin bad++; $display("[TB] FAIL cal_no_bus got=%0d want=0", q_kind.size()); end
        cal_busy = 1'b0;
    endtask

    task automatic test_cal_timeout();
        int edges;
        cal_busy = 1'b1;
        @(negedge clk);
        to_wcalib = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        to_wcalib = 1'b0;
        while (to_busy && edges < 500) begin @(posedge clk); edges++; @(negedge clk); end
        total++; if (edges != TO_SHORT + 2) begin
            bad++; $display("[TB] FAIL tmo_latency got=%0d want=%0d", edges, TO_SHORT + 2); end
        total++; if (to_cal_timeout !== 1'b1) begin bad++; $display("[TB] FAIL tmo_flag got=%b want=1", to_cal_timeout); end
        repeat (5) @(negedge clk);
        total++; if (to_cal_timeout !== 1'b1 || to_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL tmo_sticky got=%b/%b want=1/0", to_cal_timeout, to_busy); end
        cal_busy = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        total++; if (to_cal_timeout !== 1'b0) begin bad++; $display("[TB] FAIL tmo_reset_clear got=%b want=0", to_cal_timeout); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int          n;
        logic [31:0] old;
        old = $urandom;
        mem[10'h1C3] = old;
        wait_cfg = 10;
        clear_log();
        @(negedge clk);
        cmd_reconfig = 1'b1; cmd_address = 10'h1C3; cmd_data = ~old; cmd_mask = 32'hFFFF_FFFF;
        @(negedge clk);
        cmd_reconfig = 1'b0;
        n = 0;
        while (!mgmt_write && n < 60) begin @(negedge clk); n++; end
        total++; if (mgmt_write !== 1'b1) begin bad++; $display("[TB] FAIL rst_reach_wr got=%b want=1", mgmt_write); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++; if (mgmt_write !== 1'b0 || busy !== 1'b0 || mgmt_read !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_abort got=w%b/b%b/r%b want=0/0/0", mgmt_write, busy, mgmt_read); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (mem[10'h1C3] !== old || q_kind.size() != 1) begin
            bad++; $display("[TB] FAIL rst_no_write got=%h/%0d want=%h/1", mem[10'h1C3], q_kind.size(), old); end
        test_rmw_case("rst_after", 10'h1C3, 32'hCAFE_F00D, 32'hF0F0_F0F0, 0);
    endtask

`ifdef RMW_VERIFY_EN
    task automatic test_verify();
        int   edges;
        logic bf;
        total++; if (verify_err !== 1'b0) begin bad++; $display("[TB] FAIL verify_clean got=%b want=0", verify_err); end
        wait_cfg = 0;
        mem[10'h0F0] = 32'h0;
        drop_writes = 1'b1;
        clear_log();
        issue_cmd(4'b0100, 10'h0F0, 32'h0000_1234, 32'h0000_FFFF, 0, edges, bf);
        drop_writes = 1'b0;
        total++; if (verify_err !== 1'b1) begin bad++; $display("[TB] FAIL verify_err got=%b want=1", verify_err); end
        total++; if (edges != 7) begin bad++; $display("[TB] FAIL verify_latency got=%0d want=7", edges); end
    endtask
`endif

    initial begin
        cmd_reconfig = 1'b0; cmd_req_cbus = 1'b0; cmd_rel_cbus = 1'b0; cmd_wcalib = 1'b0;
        cmd_address = '0; cmd_data = '0; cmd_mask = '0;
        cal_busy = 1'b0; to_wcalib = 1'b0;
        wait_cfg = 0; drop_writes = 1'b0; proto_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        test_reset();
        test_rmw();
        test_rmw_random();
        test_waitrequest();
        test_arbitration();
        test_back_to_back();
        test_cal_wait();
        test_cal_timeout();
        test_reset_mid_write();
`ifdef RMW_VERIFY_EN
        test_verify();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
